spi_rx_mux: RTL and testbench

- Parametrised successor to the single-channel receive-to-SPI word path.
- Takes N independent receive channels, each producing words with a data/strobe pair.
- Buffers each channel in its own FIFO.
- Merges the channels round-robin onto one tagged word stream toward the SPI master, which uses a strobe/accept handshake.
- Sits between the per-line rx_top instances and spi_master in a multi-line design.

---
 rtl/spi_rx_mux.sv | 154 +++++++++++++++
 tb/tb_spi_rx_mux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_mux.sv
// Merges CHANNELS receive word streams, each buffered in its own FIFO, onto one
// tagged output word stream with a strobe/accept handshake and round-robin arbitration.
module spi_rx_mux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = 2
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]       ch_strobe,
    output logic [TAG_W+WIDTH-1:0]    out_data,
    output logic                      out_strobe,
    input  logic                      out_accept,
    output logic [CHANNELS-1:0]       overflow,
    input  logic [CHANNELS-1:0]       ovf_clear,
    output logic [CHANNELS-1:0]       ch_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]             state_r;
    logic [TAG_W+WIDTH-1:0] out_data_r;
    logic [TAG_W-1:0]       last_grant_r;
    logic [TAG_W-1:0]       grant_s;
    logic                   found_s;
    logic                   load_s;
    logic [CHANNELS-1:0]    nonempty_s;
    logic [WIDTH-1:0]       head_s [CHANNELS];

    // Per-channel circular FIFO with sticky overflow and registered empty flag
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic [PTR_W-1:0] rd_ptr_r;
        logic [PTR_W-1:0] wr_ptr_r;
        logic [CNT_W-1:0] count_r;
        logic [CNT_W-1:0] count_nxt_s;
        logic             full_s;
        logic             pop_s;
        logic             push_s;
        logic             drop_s;
        logic             empty_r;
        logic             ovf_r;

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        assign full_s        = (count_r == FULL_CNT);
        assign pop_s         = load_s && (grant_s == TAG_W'(k));
        assign push_s        = ch_strobe[k] && (!full_s || pop_s);
        assign drop_s        = ch_strobe[k] && full_s && !pop_s;
        assign nonempty_s[k] = (count_r != {CNT_W{1'b0}});
        assign head_s[k]     = mem_r[rd_ptr_r];
        assign ch_empty[k]   = empty_r;
        assign overflow[k]   = ovf_r;

        // Next occupancy from the push/pop pair
        always_comb begin
            count_nxt_s = count_r;
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end

        // Word storage
        always_ff @(posedge mclk) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= ch_data[k*WIDTH +: WIDTH];
            end
        end

        // Pointers, count and status flags
        always_ff @(posedge mclk) begin
            if (reset) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
                empty_r  <= 1'b1;
                ovf_r    <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                count_r <= count_nxt_s;
                empty_r <= (count_nxt_s == {CNT_W{1'b0}});
                if (drop_s) begin
                    ovf_r <= 1'b1;
                end else if (ovf_clear[k]) begin
                    ovf_r <= 1'b0;
                end
            end
        end
    end

    // Round-robin: lowest busy channel above last_grant, else lowest busy channel overall
    always_comb begin
        logic             hi_found;
        logic             lo_found;
        logic [TAG_W-1:0] hi_idx;
        logic [TAG_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = {TAG_W{1'b0}};
        lo_idx   = {TAG_W{1'b0}};
        for (int j = 0; j < CHANNELS; j++) begin
            if (nonempty_s[j] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = TAG_W'(j);
            end else begin
                lo_found = lo_found;
            end
            if (nonempty_s[j] && !hi_found && (j > int'(last_grant_r))) begin
                hi_found = 1'b1;
                hi_idx   = TAG_W'(j);
            end else begin
                hi_found = hi_found;
            end
        end
        found_s = lo_found;
        grant_s = hi_found ? hi_idx : lo_idx;
    end

    assign load_s = found_s && ((state_r == ST_EMPTY) || out_accept);

    // Output word stage: reloads on the accepting cycle for full throughput
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            out_data_r   <= {(TAG_W+WIDTH){1'b0}};
            last_grant_r <= TAG_W'(CHANNELS-1);
        end else if (load_s) begin
            state_r      <= ST_FULL;
            out_data_r   <= {grant_s, head_s[grant_s]};
            last_grant_r <= grant_s;
        end else if ((state_r == ST_FULL) && out_accept) begin
            state_r      <= ST_EMPTY;
        end else begin
            state_r      <= state_r;
        end
    end

    assign out_data   = out_data_r;
    assign out_strobe = (state_r == ST_FULL);

endmodule

// File: tb/tb_spi_rx_mux.sv
// Scoreboard bench for spi_rx_mux: per-channel expected-word queues plus an
// optional expected-tag queue, checked whenever a word is handed over.
module tb_spi_rx_mux;

    logic        mclk = 1'b0;
    logic        reset;
    logic [63:0] ch_data;
    logic [3:0]  ch_strobe;
    logic [17:0] out_data;
    logic        out_strobe;
    logic        out_accept;
    logic [3:0]  overflow;
    logic [3:0]  ovf_clear;
    logic [3:0]  ch_empty;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q [4][$];
    int          tag_q [$];
    bit          alt_mode = 1'b0;
    int          prev_tag = -1;

    spi_rx_mux #(.CHANNELS(4), .WIDTH(16), .DEPTH(8), .TAG_W(2)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .ch_data    (ch_data),
        .ch_strobe  (ch_strobe),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .out_accept (out_accept),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear),
        .ch_empty   (ch_empty)
    );

    always #5 mclk = ~mclk;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int qs_busy();
        int s = 0;
        for (int k = 0; k < 4; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
        ch_strobe = 4'b0000;
        ovf_clear = 4'b0000;
    endtask

    task automatic drive(input int ch, input logic [15:0] d, input bit kept);
        ch_data[ch*16 +: 16] = d;
        ch_strobe[ch]        = 1'b1;
        if (kept) exp_q[ch].push_back(d);
    endtask

    task automatic flush_model();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        tag_q.delete();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ch_strobe  = 4'b0000;
        ovf_clear  = 4'b0000;
        out_accept = 1'b0;
        flush_model();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_accept = 1'b1;
        while ((qs_busy() != 0 || out_strobe) && n < 200) begin
            tick();
            n++;
        end
        check_val("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    // Scoreboard: every handshake word must be the oldest expected word of its channel
    always @(negedge mclk) begin
        if (!reset && out_strobe && out_accept) begin
            int tag;
            tag = int'(out_data[17:16]);
            if (exp_q[tag].size() == 0) begin
                check_val("spurious_word", {14'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check_val("word_data", {16'd0, out_data[15:0]}, {16'd0, exp_q[tag].pop_front()});
            end
            if (tag_q.size() != 0) begin
                check_val("word_tag", tag, tag_q.pop_front());
            end
            if (alt_mode) begin
                check_val("alt_tag_set", 32'(tag == 0 || tag == 2), 32'd1);
                if (prev_tag >= 0) check_val("alt_tag_change", 32'(tag != prev_tag), 32'd1);
                prev_tag = tag;
            end
        end
    end

    initial begin
        ch_data    = 64'd0;
        ch_strobe  = 4'b0000;
        ovf_clear  = 4'b0000;
        out_accept = 1'b0;
        reset      = 1'b1;
        do_reset();

        // Reset state
        @(negedge mclk);
        check_val("rst_strobe",   {31'd0, out_strobe}, 32'd0);
        check_val("rst_data",     {14'd0, out_data},   32'd0);
        check_val("rst_overflow", {28'd0, overflow},   32'd0);
        check_val("rst_empty",    {28'd0, ch_empty},   32'hF);

        // Single push latency on ch2
        out_accept = 1'b1;
        tick();
        drive(2, 16'h1234, 1'b1);
        tick();
        @(negedge mclk);
        check_val("lat_strobe_early", {31'd0, out_strobe}, 32'd0);
        check_val("lat_empty_early",  {31'd0, ch_empty[2]}, 32'd0);
        tick();
        @(negedge mclk);
        check_val("lat_strobe", {31'd0, out_strobe}, 32'd1);
        check_val("lat_data",   {14'd0, out_data},   32'h2_1234);
        check_val("lat_empty",  {31'd0, ch_empty[2]}, 32'd1);
        drain();

        // All four channels at once from reset priority: strict 0,1,2,3
        do_reset();
        out_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k, 16'hC000 + 16'(k), 1'b1);
            tag_q.push_back(k);
        end
        tick();
        drain();
        check_val("rot_tags_done", tag_q.size(), 32'd0);

        // Overflow on ch1 with the output stage stalled by a ch0 word
        out_accept = 1'b0;
        drive(0, 16'hA000, 1'b1);
        tick();
        tick();
        tick();
        for (int i = 1; i <= 9; i++) begin
            drive(1, 16'h1000 + 16'(i), i <= 8);
            tick();
            if (i == 8) begin
                @(negedge mclk);
                check_val("ovf_not_yet", {31'd0, overflow[1]}, 32'd0);
            end
        end
        @(negedge mclk);
        check_val("ovf_set",    {28'd0, overflow}, 32'h2);
        check_val("ovf_hold",   {14'd0, out_data}, 32'h0_A000);
        check_val("ovf_strobe", {31'd0, out_strobe}, 32'd1);
        drain();
        check_val("ovf_sticky", {31'd0, overflow[1]}, 32'd1);
        ovf_clear[1] = 1'b1;
        tick();
        @(negedge mclk);
        check_val("ovf_cleared", {28'd0, overflow}, 32'd0);

        // Full ch3 with simultaneous pop and push
        out_accept = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            drive(3, 16'h3000 + 16'(i), 1'b1);
            tick();
        end
        @(negedge mclk);
        check_val("full3_not_empty", {31'd0, ch_empty[3]}, 32'd0);
        out_accept = 1'b1;
        drive(3, 16'hBEEF, 1'b1);
        tick();
        @(negedge mclk);
        check_val("full3_no_ovf", {31'd0, overflow[3]}, 32'd0);
        drain();

        // Alternating ch0/ch2 traffic with intermittent accept
        alt_mode = 1'b1;
        prev_tag = -1;
        for (int c = 0; c < 12; c++) begin
            out_accept = 1'($urandom_range(0, 1));
            if (c % 2 == 0) begin
                drive(0, 16'h0A00 + 16'(c), 1'b1);
                drive(2, 16'h2A00 + 16'(c), 1'b1);
            end
            tick();
        end
        drain();
        alt_mode = 1'b0;
        check_val("alt_overflow", {28'd0, overflow}, 32'd0);

        // Reset with buffered words and a held output word
        out_accept = 1'b0;
        drive(1, 16'h5001, 1'b1); tick();
        drive(1, 16'h5002, 1'b1); tick();
        drive(2, 16'h5003, 1'b1); tick();
        drive(2, 16'h5004, 1'b1); tick();
        drive(3, 16'h5005, 1'b1); tick();
        tick();
        @(negedge mclk);
        check_val("pre_rst_strobe", {31'd0, out_strobe}, 32'd1);
        check_val("pre_rst_empty",  {28'd0, ch_empty},   32'h1);
        reset = 1'b1;
        tick();
        @(negedge mclk);
        check_val("mid_rst_strobe",   {31'd0, out_strobe}, 32'd0);
        check_val("mid_rst_empty",    {28'd0, ch_empty},   32'hF);
        check_val("mid_rst_overflow", {28'd0, overflow},   32'd0);
        reset = 1'b0;
        flush_model();
        tick();
        drive(3, 16'h7003, 1'b1);
        drive(0, 16'h7000, 1'b1);
        tag_q.push_back(0);
        tag_q.push_back(3);
        out_accept = 1'b1;
        tick();
        drain();
        check_val("post_rst_tags_done", tag_q.size(), 32'd0);
        check_val("model_empty", qs_busy(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
